// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter with pause/resume, terminal flag and
//            optional auto-reload for periodic strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int Maximum_Value   = 9,
    parameter int NBitsForCounter = $clog2(Maximum_Value + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       auto_reload,
    input  logic [NBitsForCounter-1:0] load_value,
    output logic [NBitsForCounter-1:0] Counting,
    output logic                       busy,
    output logic                       Flag,
    output logic                       load_err
);

    localparam logic [NBitsForCounter-1:0] C_MAX = NBitsForCounter'(Maximum_Value);
    localparam logic [NBitsForCounter-1:0] C_ONE = NBitsForCounter'(1);
    localparam logic [NBitsForCounter-1:0] C_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [NBitsForCounter-1:0] r_reload;
    logic                       w_over;
    logic [NBitsForCounter-1:0] w_load_sat;

    assign w_over     = (load_value > C_MAX);
    assign w_load_sat = w_over ? C_MAX : load_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_reload <= C_ZERO;
            Counting <= C_ZERO;
            busy     <= 1'b0;
            Flag     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            Flag     <= 1'b0;
            load_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        load_err <= w_over;
                        r_reload <= w_load_sat;
                        Counting <= w_load_sat;
                        if (w_load_sat == C_ZERO) begin
                            Flag <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // stop outranks a coinciding terminal tick
                    if (stop) begin
                        r_state <= S_PAUSE;
                    end else if (enb) begin
                        if (Counting <= C_ONE) begin
                            Flag <= 1'b1;
                            if (auto_reload) begin
                                Counting <= r_reload;
                            end else begin
                                Counting <= C_ZERO;
                                r_state  <= S_IDLE;
                                busy     <= 1'b0;
                            end
                        end else begin
                            Counting <= Counting - C_ONE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        Counting <= C_ZERO;
                        r_state  <= S_IDLE;
                        busy     <= 1'b0;
                    end else if (start) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    Counting <= C_ZERO;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
